// File: rtl/cpu_pkg.sv
// ============================================================================
//  cpu_pkg
//  Widths shared by the control unit, the memories and the data-memory dumper.
//  Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DM_ADDR_W = 8;
  localparam int WORD_W    = 16;

  // Dump sequencer state encoding
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_READ    = 3'd1;
  localparam logic [STATE_W-1:0] S_CAPTURE = 3'd2;
  localparam logic [STATE_W-1:0] S_SEND_HI = 3'd3;
  localparam logic [STATE_W-1:0] S_SEND_LO = 3'd4;
  localparam logic [STATE_W-1:0] S_NEXT    = 3'd5;
  localparam logic [STATE_W-1:0] S_DONE    = 3'd6;

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
//  uart_tx_byte
//  8N1 serialiser; a start may be accepted in the last stop-bit cycle.
//  Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [8:0]       shreg;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign tx_done = active && bit_end && (bit_idx == 4'd9);

  // bit_idx 0 is the start bit, 1..8 data, 9 stop; shreg holds the bits still to go
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (start && (!active || tx_done)) begin
      active  <= 1'b1;
      tx      <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= {1'b1, data};
    end else if (active) begin
      if (bit_end) begin
        cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dm_uart_dumper.sv
// ============================================================================
//  dm_uart_dumper
//  After end_process rises, streams WORD_COUNT data-memory words out over UART.
//  Rev 1.0
// ============================================================================
`default_nettype none

module dm_uart_dumper
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = DM_ADDR_W,
  parameter int START_ADDR   = 0,
  parameter int WORD_COUNT   = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              end_process,
  output logic              dm_rd_en,
  output logic [ADDR_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_INIT   = START_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   WORDS_TOTAL = WORD_COUNT[ADDR_W:0];

  logic               ep_q;
  logic               ep_prev;
  logic               rise;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [ADDR_W:0]    words_sent;
  logic [7:0]         lo_byte;
  logic               last;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_done;

  assign rise = ep_q && !ep_prev;
  assign last = (words_sent == WORDS_TOTAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ep_q    <= 1'b0;
      ep_prev <= 1'b0;
      state   <= S_IDLE;
    end else begin
      ep_q    <= end_process;
      ep_prev <= ep_q;
      state   <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (rise) state_next = S_READ;
      S_READ:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_SEND_HI;
      S_SEND_HI: if (tx_done) state_next = S_SEND_LO;
      S_SEND_LO: if (tx_done) state_next = S_NEXT;
      S_NEXT:    state_next = last ? S_DONE : S_READ;
      S_DONE:    state_next = S_DONE;
      default:   state_next = S_IDLE;
    endcase
  end

  // The high byte is launched straight from dm_rdata so its start bit leaves one cycle after capture
  always_comb begin
    dm_rd_en = (state == S_READ);
    tx_start = (state == S_CAPTURE) || ((state == S_SEND_HI) && tx_done);
    tx_data  = (state == S_CAPTURE) ? dm_rdata[15:8] : lo_byte;
    done     = (state == S_DONE) || ((state == S_NEXT) && last);
    busy     = (state != S_IDLE) && !done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_addr    <= ADDR_INIT;
      words_sent <= '0;
      lo_byte    <= '0;
    end else begin
      if (state == S_CAPTURE)
        lo_byte <= dm_rdata[7:0];
      if ((state == S_SEND_LO) && tx_done)
        words_sent <= words_sent + 1'b1;
      if ((state == S_NEXT) && !last)
        dm_addr <= dm_addr + 1'b1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (tx_start),
    .data   (tx_data),
    .tx     (tx),
    .tx_done(tx_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_dm_uart_dumper.sv
// ============================================================================
//  tb_dm_uart_dumper
//  Directed bench: three dumper configurations, each with its own DM model.
//  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dm_uart_dumper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // A: CLKS_PER_BIT=4, ADDR_W=8, START=0, WORD_COUNT=2
  logic        ep_a = 1'b0, rd_a, tx_a, busy_a, done_a;
  logic [7:0]  addr_a;
  logic [15:0] rdata_a;
  logic [15:0] mem_a [256];
  logic [7:0]  log_a [8];
  int          nlog_a;

  // B: CLKS_PER_BIT=4, ADDR_W=4, START=15, WORD_COUNT=2
  logic        ep_b = 1'b0, rd_b, tx_b, busy_b, done_b;
  logic [3:0]  addr_b;
  logic [15:0] rdata_b;
  logic [15:0] mem_b [16];
  logic [3:0]  log_b [8];
  int          nlog_b;

  // C: CLKS_PER_BIT=434, ADDR_W=8, START=0, WORD_COUNT=1
  logic        ep_c = 1'b0, rd_c, tx_c, busy_c, done_c;
  logic [7:0]  addr_c;
  logic [15:0] rdata_c;
  logic [15:0] mem_c [256];

  dm_uart_dumper #(.CLKS_PER_BIT(4), .ADDR_W(8), .START_ADDR(0), .WORD_COUNT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .end_process(ep_a), .dm_rd_en(rd_a), .dm_addr(addr_a),
    .dm_rdata(rdata_a), .tx(tx_a), .busy(busy_a), .done(done_a));

  dm_uart_dumper #(.CLKS_PER_BIT(4), .ADDR_W(4), .START_ADDR(15), .WORD_COUNT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .end_process(ep_b), .dm_rd_en(rd_b), .dm_addr(addr_b),
    .dm_rdata(rdata_b), .tx(tx_b), .busy(busy_b), .done(done_b));

  dm_uart_dumper #(.CLKS_PER_BIT(434), .ADDR_W(8), .START_ADDR(0), .WORD_COUNT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .end_process(ep_c), .dm_rd_en(rd_c), .dm_addr(addr_c),
    .dm_rdata(rdata_c), .tx(tx_c), .busy(busy_c), .done(done_c));

  // Synchronous-read memories; read addresses are logged and the log clears on reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) nlog_a <= 0;
    else if (rd_a) begin
      rdata_a <= mem_a[addr_a];
      if (nlog_a < 8) log_a[nlog_a] <= addr_a;
      nlog_a <= nlog_a + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) nlog_b <= 0;
    else if (rd_b) begin
      rdata_b <= mem_b[addr_b];
      if (nlog_b < 8) log_b[nlog_b] <= addr_b;
      nlog_b <= nlog_b + 1;
    end
  end

  always @(posedge clk) if (rd_c) rdata_c <= mem_c[addr_c];

  function automatic logic cur_tx(input int w);
    case (w)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    ep_a = 1'b0; ep_b = 1'b0; ep_c = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Checks every cycle of one frame against the expected bit pattern.
  // wait_fall=0 requires the start bit at the very next cycle (no idle gap).
  task automatic rx_check(input int w, input int cpb, input logic [7:0] exp,
                          input bit wait_fall, input string name);
    logic [9:0] frame;
    logic [7:0] got;
    int errs, bound;
    frame = {1'b1, exp, 1'b0};
    got = '0;
    errs = 0;
    bound = 0;
    @(negedge clk);
    if (wait_fall)
      while (cur_tx(w) !== 1'b0 && bound < 100 * cpb) begin
        @(negedge clk);
        bound++;
      end
    for (int k = 0; k < 10 * cpb; k++) begin
      if (k > 0) @(negedge clk);
      if (cur_tx(w) !== frame[k / cpb]) errs++;
      if ((k % cpb) == cpb / 2 && k / cpb >= 1 && k / cpb <= 8) got[k / cpb - 1] = cur_tx(w);
    end
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL %s: decoded %02h with %0d bad bit-cycles, expected %02h", name, got, errs, exp);
    end
  endtask

  task automatic pulse_a;
    @(negedge clk); ep_a = 1'b1;
    repeat (2) @(negedge clk); ep_a = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    tests++;
    if ({tx_a, busy_a, done_a, rd_a, addr_a} !== {4'b1000, 8'h00}) begin
      fails++;
      $display("FAIL reset_a: got tx/busy/done/rd/addr=%b/%b/%b/%b/%02h, expected 1/0/0/0/00",
               tx_a, busy_a, done_a, rd_a, addr_a);
    end
    tests++;
    if ({tx_b, busy_b, done_b, rd_b, addr_b} !== {4'b1000, 4'hF}) begin
      fails++;
      $display("FAIL reset_b: got tx/busy/done/rd/addr=%b/%b/%b/%b/%h, expected 1/0/0/0/f",
               tx_b, busy_b, done_b, rd_b, addr_b);
    end
  endtask

  task automatic test_basic_dump;
    do_reset();
    pulse_a();
    tests++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy: got busy=%b done=%b, expected 1 0", busy_a, done_a);
    end
    rx_check(0, 4, 8'h12, 1'b1, "basic_b0");
    rx_check(0, 4, 8'h34, 1'b0, "basic_b1");
    rx_check(0, 4, 8'hAB, 1'b1, "basic_b2");
    rx_check(0, 4, 8'hCD, 1'b0, "basic_b3");
    @(negedge clk);
    tests++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || tx_a !== 1'b1) begin
      fails++;
      $display("FAIL basic_done: got done=%b busy=%b tx=%b, expected 1 0 1", done_a, busy_a, tx_a);
    end
    tests++;
    if (nlog_a != 2 || log_a[0] !== 8'h00 || log_a[1] !== 8'h01) begin
      fails++;
      $display("FAIL basic_addrs: got %0d reads %02h %02h, expected 2 reads 00 01",
               nlog_a, log_a[0], log_a[1]);
    end
  endtask

  task automatic test_latency;
    do_reset();
    @(negedge clk); ep_a = 1'b1;
    @(negedge clk);
    tests++;
    if (rd_a !== 1'b0 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL lat_T: got rd=%b busy=%b, expected 0 0", rd_a, busy_a);
    end
    @(negedge clk); ep_a = 1'b0;
    tests++;
    if (rd_a !== 1'b1 || addr_a !== 8'h00 || busy_a !== 1'b1) begin
      fails++;
      $display("FAIL lat_T1: got rd=%b addr=%02h busy=%b, expected 1 00 1", rd_a, addr_a, busy_a);
    end
    @(negedge clk);
    tests++;
    if (rd_a !== 1'b0 || tx_a !== 1'b1) begin
      fails++;
      $display("FAIL lat_T2: got rd=%b tx=%b, expected 0 1", rd_a, tx_a);
    end
    @(negedge clk);
    tests++;
    if (tx_a !== 1'b0) begin
      fails++;
      $display("FAIL lat_T3: got tx=%b, expected 0", tx_a);
    end
    for (int i = 0; i < 400 && done_a !== 1'b1; i++) @(negedge clk);
    tests++;
    if (done_a !== 1'b1) begin
      fails++;
      $display("FAIL lat_done: got done=%b within budget, expected 1", done_a);
    end
  endtask

  task automatic test_single_dump;
    int bad;
    do_reset();
    @(negedge clk); ep_a = 1'b1;
    rx_check(0, 4, 8'h12, 1'b1, "hold_b0");
    rx_check(0, 4, 8'h34, 1'b0, "hold_b1");
    rx_check(0, 4, 8'hAB, 1'b1, "hold_b2");
    rx_check(0, 4, 8'hCD, 1'b0, "hold_b3");
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || rd_a !== 1'b0 || done_a !== 1'b1) bad++;
    end
    ep_a = 1'b0;
    repeat (5) @(negedge clk);
    ep_a = 1'b1;
    repeat (5) @(negedge clk);
    ep_a = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || rd_a !== 1'b0 || done_a !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0 || nlog_a != 2) begin
      fails++;
      $display("FAIL hold_once: got %0d bad idle cycles and %0d reads, expected 0 and 2", bad, nlog_a);
    end
  endtask

  task automatic test_reset_mid_frame;
    do_reset();
    pulse_a();
    rx_check(0, 4, 8'h12, 1'b1, "rst_b0");
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || rd_a !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: got tx=%b busy=%b done=%b rd=%b, expected 1 0 0 0",
               tx_a, busy_a, done_a, rd_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_a();
    rx_check(0, 4, 8'h12, 1'b1, "rst_again_b0");
    rx_check(0, 4, 8'h34, 1'b0, "rst_again_b1");
    tests++;
    if (log_a[0] !== 8'h00) begin
      fails++;
      $display("FAIL rst_restart_addr: got %02h, expected 00", log_a[0]);
    end
  endtask

  task automatic test_addr_wrap;
    do_reset();
    @(negedge clk); ep_b = 1'b1;
    repeat (2) @(negedge clk); ep_b = 1'b0;
    rx_check(1, 4, 8'hBE, 1'b1, "wrap_b0");
    rx_check(1, 4, 8'hEF, 1'b0, "wrap_b1");
    rx_check(1, 4, 8'h01, 1'b1, "wrap_b2");
    rx_check(1, 4, 8'h02, 1'b0, "wrap_b3");
    @(negedge clk);
    tests++;
    if (nlog_b != 2 || log_b[0] !== 4'hF || log_b[1] !== 4'h0 || done_b !== 1'b1 || busy_b !== 1'b0) begin
      fails++;
      $display("FAIL wrap_addrs: got %0d reads %h %h done=%b busy=%b, expected 2 reads f 0 done=1 busy=0",
               nlog_b, log_b[0], log_b[1], done_b, busy_b);
    end
  endtask

  task automatic test_full_baud;
    do_reset();
    @(negedge clk); ep_c = 1'b1;
    repeat (2) @(negedge clk); ep_c = 1'b0;
    rx_check(2, 434, 8'h00, 1'b1, "baud_b0");
    rx_check(2, 434, 8'hFF, 1'b0, "baud_b1");
    @(negedge clk);
    tests++;
    if (done_c !== 1'b1 || busy_c !== 1'b0 || tx_c !== 1'b1) begin
      fails++;
      $display("FAIL baud_done: got done=%b busy=%b tx=%b, expected 1 0 1", done_c, busy_c, tx_c);
    end
  endtask

  initial begin
    mem_a[0] = 16'h1234;
    mem_a[1] = 16'hABCD;
    mem_a[2] = 16'h5555;
    mem_b[15] = 16'hBEEF;
    mem_b[0]  = 16'h0102;
    mem_b[14] = 16'h7777;
    mem_c[0] = 16'h00FF;
    mem_c[1] = 16'h3333;

    test_reset();
    test_basic_dump();
    test_latency();
    test_single_dump();
    test_reset_mid_frame();
    test_addr_wrap();
    test_full_baud();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
